r200_dmem_resp: RTL
===================

# r200_dmem_resp

Data-memory responder for the r200 pipeline: it services load/store requests issued from the MEM stage over a valid/ready request channel and returns load data (or store completion) over a valid/ready response channel. It owns a word-organised RAM, performs RV32I byte-lane selection and sign/zero extension, and flags misaligned, out-of-range and illegal-width accesses. One transaction is outstanding at a time, with a programmable number of wait states.

## Interface
Parameters:
- DEPTH_WORDS, 1024: RAM depth in 32-bit words; power of two.
- WAIT_STATES, 0: extra cycles between accept and response; 0..15.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset; synchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept; high only in IDLE.
- req_we  in  1  1 = store, 0 = load.
- req_func3  in  3  RV32I width code (load: 0 lb, 1 lh, 2 lw, 4 lbu, 5 lhu; store: 0 sb, 1 sh, 2 sw).
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts response.
- rsp_rdata  out  32  extended load data; 0 for stores and errored accesses.
- rsp_err  out  1  access faulted; no RAM write occurred.

## Operation
- States: IDLE, WAIT, RESP.
- IDLE: req_ready=1. On req_valid&&req_ready: latch we/func3/addr/wdata, compute err; go to RESP if WAIT_STATES==0, else load wait counter with WAIT_STATES-1 and go to WAIT.
- WAIT: req_ready=0; counter decrements each cycle; at counter==0 go to RESP.
- Commit: on the edge entering RESP, if !err: store writes selected lanes; load samples RAM word, extends it into rsp_rdata. rsp_err registered at the same edge.
- RESP: rsp_valid=1, outputs held stable until rsp_valid&&rsp_ready, then IDLE. No new request accepted in the same cycle.
- err set when: func3 not in legal set for direction (load 3/6/7, store ≥3); halfword with addr[0]=1; word with addr[1:0]≠0; addr ≥ 4*DEPTH_WORDS.
- Word index = addr[2 +: log2(DEPTH_WORDS)].
- Store lanes: sb lane addr[1:0] ← wdata[7:0]; sh lanes {addr[1],0..+1} ← wdata[15:0]; sw all ← wdata.
- Load extend: lb/lh sign-extend, lbu/lhu zero-extend selected byte/half; lw unchanged.
- RAM contents are not reset.

## Timing
- Reset values: state IDLE, req_ready=1 (from the cycle after rst deasserts; 0 while rst=1), rsp_valid=0, rsp_rdata=0, rsp_err=0, counter 0.
- Accept at edge N → rsp_valid high from cycle N+1+WAIT_STATES.
- Minimum transaction period: 2+WAIT_STATES cycles with rsp_ready held high.
- Back-pressure: rsp_ready low holds RESP indefinitely; data/err unchanged.
- Store followed by load to same word: load sees new data (write commits before the store response is visible).
- Reset mid-transaction (WAIT or RESP): transaction dropped, no response emitted; rst asserted on the commit edge suppresses the RAM write.
- req_valid may drop without acceptance; no state change.

## Structure
- Package r200_mem_pkg: func3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU), state enum, DATA_W=32.
- Sub-module r200_ldst_align (combinational): byte-enable/shifted write data generation, load lane select and extension, alignment/func3 error check.
- RAM inferred as a 32-bit array with per-byte write enables.

## Test plan
- WAIT_STATES=0: sw 0xDEADBEEF @0x10, then lw @0x10 → rsp_rdata=0xDEADBEEF, rsp_err=0, rsp_valid one cycle after each accept.
- Lanes: after sw 0x00000000 @0x20, sb 0x80 @0x23 → lb @0x23 = 0xFFFFFF80, lbu = 0x00000080, lw = 0x80000000.
- Half: sh 0x8001 @0x32 → lh @0x32 = 0xFFFF8001, lhu = 0x00008001; lh @0x33 → rsp_err=1, rdata=0.
- Faults: sw @0x11 → err=1 and word @0x10 unchanged; lw @4*DEPTH_WORDS → err=1; load func3=3 → err=1.
- WAIT_STATES=3 with rsp_ready low 5 cycles: rsp_valid at accept+4, held stable until rsp_ready, req_ready=0 throughout.
- rst pulsed during WAIT of sw 0x12345678 @0x40 (prior 0) → no response; subsequent lw @0x40 = 0.

Source files
------------

// File: rtl/r200_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : r200_mem_pkg
// Purpose  : Shared definitions for the r200 data-memory responder: RV32I
//            load/store width codes, responder state encoding, data width.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package r200_mem_pkg;

  localparam int DATA_W = 32;

  // RV32I funct3 width codes (loads use all five, stores only B/H/W)
  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

endpackage
`default_nettype wire

// File: rtl/r200_ldst_align.sv
`default_nettype none
// ============================================================================
// Module   : r200_ldst_align
// Purpose  : Combinational load/store lane logic. Produces byte enables and
//            lane-replicated store data, selects and extends load data from a
//            RAM word, and flags illegal width codes and misalignment.
// Ports    : we_i       1 = store, 0 = load
//            func3_i    RV32I width code
//            addr_lo_i  byte offset within the word
//            wdata_i    right-aligned store data
//            rword_i    RAM word at the addressed index
//            be_o       per-byte write enables
//            wdata_o    store data replicated onto its lanes
//            rdata_o    extended load data
//            err_o      illegal func3 for direction or misaligned access
// Revision : 1.0 - initial release
// ============================================================================
module r200_ldst_align
  import r200_mem_pkg::*;
(
  input  logic [2:0]        func3_i,
  input  logic              we_i,
  input  logic [1:0]        addr_lo_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [DATA_W-1:0] rword_i,
  output logic [3:0]        be_o,
  output logic [DATA_W-1:0] wdata_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic              err_o
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = rword_i[{addr_lo_i, 3'b000} +: 8];
  assign w_half = addr_lo_i[1] ? rword_i[31:16] : rword_i[15:0];

  // Store data is replicated across all lanes so the byte enables alone
  // decide which lanes land in the RAM.
  always_comb begin
    be_o    = 4'b0000;
    wdata_o = '0;
    rdata_o = '0;
    err_o   = 1'b0;
    case (func3_i)
      F3_B: begin
        be_o    = 4'b0001 << addr_lo_i;
        wdata_o = {4{wdata_i[7:0]}};
        rdata_o = {{24{w_byte[7]}}, w_byte};
      end
      F3_H: begin
        err_o   = addr_lo_i[0];
        be_o    = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        wdata_o = {2{wdata_i[15:0]}};
        rdata_o = {{16{w_half[15]}}, w_half};
      end
      F3_W: begin
        err_o   = |addr_lo_i;
        be_o    = 4'b1111;
        wdata_o = wdata_i;
        rdata_o = rword_i;
      end
      F3_BU: begin
        err_o   = we_i;
        rdata_o = {24'd0, w_byte};
      end
      F3_HU: begin
        err_o   = we_i | addr_lo_i[0];
        rdata_o = {16'd0, w_half};
      end
      default: err_o = 1'b1;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/r200_dmem_resp.sv
`default_nettype none
// ============================================================================
// Module   : r200_dmem_resp
// Purpose  : Data-memory responder for the r200 MEM stage. Accepts one
//            load/store at a time, waits WAIT_STATES cycles, commits to a
//            word RAM and returns extended load data or an error flag.
// Ports    : clk, rst               clock, synchronous active-high reset
//            req_valid_i/ready_o    request handshake (ready only in IDLE)
//            req_we_i, req_func3_i  direction and RV32I width code
//            req_addr_i, wdata_i    byte address, right-aligned store data
//            rsp_valid_o/ready_i    response handshake
//            rsp_rdata_o, rsp_err_o load data (0 on store/error), fault flag
// Revision : 1.0 - initial release
// ============================================================================
module r200_dmem_resp
  import r200_mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [2:0]        req_func3_i,
  input  logic [31:0]       req_addr_i,
  input  logic [DATA_W-1:0] req_wdata_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [DATA_W-1:0] rsp_rdata_o,
  output logic              rsp_err_o
);

  localparam int         AW        = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WAIT_INIT = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  state_e            state_q, state_d;
  logic [3:0]        cnt_q;
  logic              we_q;
  logic [2:0]        func3_q;
  logic [31:0]       addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic              err_q;
  logic [DATA_W-1:0] mem_q [DEPTH_WORDS];

  logic              w_accept, w_commit, w_from_req;
  logic              w_we, w_align_err, w_oor, w_err;
  logic [2:0]        w_func3;
  logic [31:0]       w_addr;
  logic [DATA_W-1:0] w_wdata, w_wdata_sh, w_ld_data, w_rword;
  logic [3:0]        w_be;
  logic [AW-1:0]     w_idx;

  assign w_accept = req_valid_i & req_ready_o;

  // The commit edge is the one entering RESP. With zero wait states that is
  // the accept edge itself, so the transaction fields come straight from the
  // request port instead of the latched copy.
  assign w_commit   = ((state_q == ST_IDLE) && w_accept && (WAIT_STATES == 0)) ||
                      ((state_q == ST_WAIT) && (cnt_q == 4'd0));
  assign w_from_req = (state_q == ST_IDLE);
  assign w_we       = w_from_req ? req_we_i    : we_q;
  assign w_func3    = w_from_req ? req_func3_i : func3_q;
  assign w_addr     = w_from_req ? req_addr_i  : addr_q;
  assign w_wdata    = w_from_req ? req_wdata_i : wdata_q;

  assign w_idx   = w_addr[2 +: AW];
  assign w_oor   = (w_addr >> (AW + 2)) != 32'd0;
  assign w_err   = w_align_err | w_oor;
  assign w_rword = mem_q[w_idx];

  r200_ldst_align u_align (
    .func3_i   (w_func3),
    .we_i      (w_we),
    .addr_lo_i (w_addr[1:0]),
    .wdata_i   (w_wdata),
    .rword_i   (w_rword),
    .be_o      (w_be),
    .wdata_o   (w_wdata_sh),
    .rdata_o   (w_ld_data),
    .err_o     (w_align_err)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (w_accept) state_d = (WAIT_STATES == 0) ? ST_RESP : ST_WAIT;
      ST_WAIT: if (cnt_q == 4'd0) state_d = ST_RESP;
      ST_RESP: if (rsp_ready_i) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Handshake outputs; ready is masked during reset so nothing is accepted
  // on an edge that also clears the FSM.
  always_comb begin
    req_ready_o = (state_q == ST_IDLE) && !rst;
    rsp_valid_o = (state_q == ST_RESP);
  end

  // Transaction latch, wait counter and response registers
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      func3_q <= 3'd0;
      addr_q  <= 32'd0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (w_accept) begin
        we_q    <= req_we_i;
        func3_q <= req_func3_i;
        addr_q  <= req_addr_i;
        wdata_q <= req_wdata_i;
        cnt_q   <= WAIT_INIT;
      end else if ((state_q == ST_WAIT) && (cnt_q != 4'd0)) begin
        cnt_q <= cnt_q - 4'd1;
      end
      if (w_commit) begin
        rdata_q <= (!w_err && !w_we) ? w_ld_data : '0;
        err_q   <= w_err;
      end
    end
  end

  // RAM: not reset, per-byte write enables
  always_ff @(posedge clk) begin
    if (!rst && w_commit && w_we && !w_err) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) mem_q[w_idx][8*b +: 8] <= w_wdata_sh[8*b +: 8];
      end
    end
  end

  assign rsp_rdata_o = rdata_q;
  assign rsp_err_o   = err_q;

endmodule
`default_nettype wire
